// File: rtl/sipo_rx.sv
// UART receive shifter: recovers start/8-data/parity/stop frames from an oversampled
// serial line and presents each byte with a one-cycle valid strobe plus error flags.
module sipo_rx #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       baud_clk,
  input  logic       reset,
  input  logic       data_rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       active_flag
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      sync_reg;
  logic [TW-1:0]   tick_cnt_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      shift_reg;
  logic            parity_bit_reg;
  logic            rx_s, rx_prev, tick_mid, tick_end;

  assign rx_s     = sync_reg[1];
  assign rx_prev  = sync_reg[2];
  assign tick_mid = (tick_cnt_reg == TICK_MID);
  assign tick_end = (tick_cnt_reg == TICK_END);

  // Two synchronizer stages plus one history flop for falling-edge detection.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) sync_reg <= 3'b111;
    else       sync_reg <= {sync_reg[1:0], data_rx};
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (rx_prev && !rx_s) state_next = START;
      START:  if (tick_mid) state_next = rx_s ? IDLE : DATA;
      DATA:   if (tick_end && bit_cnt_reg == 3'd7) state_next = PARITY;
      PARITY: if (tick_end) state_next = STOP;
      STOP:   if (tick_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      tick_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
      data_out       <= 8'h00;
      data_valid     <= 1'b0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state_next != state_reg) tick_cnt_reg <= '0;
      else                         tick_cnt_reg <= tick_cnt_reg + 1'b1;

      case (state_reg)
        START: if (tick_mid) bit_cnt_reg <= '0;
        DATA: if (tick_end) begin
          shift_reg   <= {rx_s, shift_reg[7:1]};
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
        PARITY: if (tick_end) parity_bit_reg <= rx_s;
        STOP: if (tick_end) begin
          // A bad stop bit still delivers the byte; only the flag reports it.
          data_out      <= shift_reg;
          parity_error  <= ((^shift_reg) ^ parity_bit_reg) != PARITY_ODD;
          framing_error <= ~rx_s;
          data_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign active_flag = (state_reg != IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: frames are driven bit by bit, expected bytes are queued
// at frame start and compared when data_valid pulses.
module tb_sipo_rx;

  localparam int OS = 16;

  logic       baud_clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_error, framing_error, active_flag;

  sipo_rx #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut (
    .baud_clk     (baud_clk),
    .reset        (reset),
    .data_rx      (data_rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .active_flag  (active_flag)
  );

  always #5 baud_clk = ~baud_clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int prev_valid_cyc = 0;
  int last_valid_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic last_perr = 1'b0;
  logic last_ferr = 1'b0;

  always @(posedge baud_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every strobe must match the oldest queued frame.
  always @(negedge baud_clk) begin
    if (!reset && data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(data_valid), 32'd0);
      end else begin
        exp_t e;
        int lat;
        e = exp_q.pop_front();
        lat = cyc - e.start;
        check("data_out", 32'(data_out), 32'(e.data));
        check("parity_error", 32'(parity_error), 32'(e.perr));
        check("framing_error", 32'(framing_error), 32'(e.ferr));
        check("active_at_valid", 32'(active_flag), 32'd0);
        check("valid_latency", 32'(lat >= 171 && lat <= 172), 32'd1);
        $display("[TB] frame %02h perr=%0b ferr=%0b latency=%0d", data_out, parity_error,
                 framing_error, lat);
        last_data = e.data;
        last_perr = e.perr;
        last_ferr = e.ferr;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
    end
  end

  task automatic hold(input logic b, input int n);
    data_rx = b;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit chk);
    exp_t e;
    e.data  = d;
    e.perr  = ((^d) ^ p) != 1'b0;
    e.ferr  = ~s;
    e.start = cyc;
    exp_q.push_back(e);
    data_rx = 1'b0;
    if (chk) begin
      repeat (2) @(negedge baud_clk);
      check("active_at_E", 32'(active_flag), 32'd0);
      @(negedge baud_clk);
      check("active_at_E+1", 32'(active_flag), 32'd1);
      repeat (OS - 3) @(negedge baud_clk);
    end else begin
      repeat (OS) @(negedge baud_clk);
    end
    for (int i = 0; i < 8; i++) hold(d[i], OS);
    hold(p, OS);
    if (chk) begin
      hold(s, 10);
      check("active_at_E+168", 32'(active_flag), 32'd1);
      hold(s, OS - 10);
    end else begin
      hold(s, OS);
    end
  endtask

  initial begin
    logic [7:0] v55;
    v55 = 8'h55;
    repeat (3) @(negedge baud_clk);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_perr", 32'(parity_error), 32'd0);
    check("rst_ferr", 32'(framing_error), 32'd0);
    check("rst_active", 32'(active_flag), 32'd0);
    reset = 1'b0;
    hold(1'b1, 20);

    // Clean frame with timing checks on active_flag.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    hold(1'b1, 20);

    // Wrong parity, then a correct frame clears the flag.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 20);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 20);

    // Bad stop bit, line stays low: no restart until a fresh falling edge.
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 32);
    check("low_line_idle_mid", 32'(active_flag), 32'd0);
    hold(1'b0, 32);
    check("low_line_idle_end", 32'(active_flag), 32'd0);
    hold(1'b1, 32);
    send_frame(8'h96, 1'b0, 1'b1, 1'b0);
    hold(1'b1, 20);

    // 4-cycle glitch: false start, no strobe, outputs unchanged.
    data_rx = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge baud_clk);
      if (k == 4) data_rx = 1'b1;
      if (k == 3) check("glitch_active_E+1", 32'(active_flag), 32'd1);
      if (k == 10) check("glitch_active_E+8", 32'(active_flag), 32'd1);
      if (k == 11) check("glitch_idle_E+9", 32'(active_flag), 32'd0);
    end
    check("glitch_data_kept", 32'(data_out), 32'(last_data));
    check("glitch_perr_kept", 32'(parity_error), 32'(last_perr));
    check("glitch_ferr_kept", 32'(framing_error), 32'(last_ferr));

    // Reset in the middle of data bit 4 of 0x55, released during its stop bit.
    hold(1'b0, OS);
    for (int i = 0; i < 4; i++) hold(v55[i], OS);
    hold(v55[4], OS / 2);
    reset = 1'b1;
    #1;
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_perr", 32'(parity_error), 32'd0);
    check("midrst_ferr", 32'(framing_error), 32'd0);
    check("midrst_active", 32'(active_flag), 32'd0);
    last_data = 8'h00;
    last_perr = 1'b0;
    last_ferr = 1'b0;
    repeat (OS / 2) @(negedge baud_clk);
    for (int i = 5; i < 8; i++) hold(v55[i], OS);
    hold(1'b0, OS);
    hold(1'b1, OS / 2);
    reset = 1'b0;
    hold(1'b1, 40);
    check("post_rst_idle", 32'(active_flag), 32'd0);
    check("post_rst_data", 32'(data_out), 32'd0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    hold(1'b1, 20);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    hold(1'b1, 30);
    check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd176);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out UART receive stage, the downstream counterpart of the transmit shifter. It recovers 11-bit frames from the serial line: start (0), 8 data bits LSB first, parity, stop (1). It runs on an oversampled baud clock, delivers each byte with a one-cycle valid strobe, and flags parity and framing errors.

## Interface
- OVERSAMPLE, 16: baud_clk cycles per bit. Power of two, ≥4.
- PARITY_ODD, 0: 0 = even parity expected over data bits; 1 = odd.
- baud_clk  input  1  clock at OVERSAMPLE × bit rate; single clock domain
- reset  input  1  asynchronous, active-high reset
- data_rx  input  1  serial line, idle high; asynchronous to baud_clk
- data_out  output  8  last received byte; held until the next frame completes
- data_valid  output  1  one-cycle pulse when data_out/error flags update
- parity_error  output  1  received parity ≠ expected; updates with data_valid, then held
- framing_error  output  1  stop bit sampled 0; updates with data_valid, then held
- active_flag  output  1  high in every state except IDLE

## Operation
- Input conditioning: 2-flop synchronizer on data_rx gives rx_s. A third flop gives rx_prev. All three reset to 1.
- Start detect: only on a falling edge (rx_prev=1, rx_s=0) while in IDLE. A line held low never starts a frame.
- tick_cnt: log2(OVERSAMPLE) bits, cleared on every state change.
- bit_cnt: 3 bits.
- Shift register: shifts right, new bit enters at [7], so the first data bit lands at data_out[0].
- States:
  - IDLE: on falling edge → START.
  - START: at tick_cnt = OVERSAMPLE/2−1 (mid start bit), rx_s=0 → DATA with bit_cnt=0. rx_s=1 → IDLE (false start; no strobe, flags unchanged).
  - DATA: at tick_cnt = OVERSAMPLE−1, shift in rx_s and increment bit_cnt. After the 8th bit (bit_cnt wraps 7→0) → PARITY.
  - PARITY: at tick_cnt = OVERSAMPLE−1, capture rx_s as the parity bit → STOP.
  - STOP: at tick_cnt = OVERSAMPLE−1, sample the stop bit and → IDLE. On the next edge register:
    - data_out ← shift register
    - parity_error ← (^data ^ parity_bit) ≠ PARITY_ODD
    - framing_error ← ~stop_bit
    - data_valid ← 1 for one cycle
- A framing error still delivers the byte.
- Reset (any time, including mid-frame) forces:
  - state IDLE; tick_cnt, bit_cnt and shift register 0
  - data_out 8'h00; data_valid, parity_error, framing_error, active_flag 0
  - synchronizer flops 1
- After reset, a frame already in progress on the line is ignored until a fresh falling edge.

## Timing
- Let E be the cycle in which IDLE sees the synchronized falling edge. E falls 2–3 baud_clk edges after the pin transition.
- active_flag goes high at E+1.
- Sample points, with H = OVERSAMPLE/2:
  - Start check: E+H.
  - Data bit k (k = 0..7): E+H+(k+1)·OVERSAMPLE.
  - Parity: E+H+9·OVERSAMPLE.
  - Stop: E+H+10·OVERSAMPLE.
- data_valid is high exactly in cycle E+H+10·OVERSAMPLE+1. For OVERSAMPLE=16 that is E+169, and active_flag is low in the same cycle.
- Back-to-back frames: the state returns to IDLE mid stop bit, so a next start edge arriving OVERSAMPLE/2 cycles later is caught. No idle gap is required.
- Accepted bit-rate tolerance is roughly ±4%, set by mid-bit sampling over 10.5 bit periods.

## Test plan
- Frame 0xA5 with parity 0 (even), stop 1, OVERSAMPLE=16 → data_valid pulses once at E+169, data_out=8'hA5, parity_error=0, framing_error=0, active_flag high E+1..E+168.
- Frame 0x3C with parity bit 1 (wrong for even) → data_out=8'h3C, parity_error=1, framing_error=0. A following correct frame 0x01 (parity 1) clears parity_error to 0.
- Frame 0x7E with stop bit 0, then line held low 64 cycles, then high → framing_error=1 and data_out=8'h7E. No second start while low; the next falling edge starts a normal frame.
- 4-cycle low glitch on an idle line → active_flag high E+1..E+8, returns to IDLE, no data_valid, outputs unchanged.
- Reset asserted during DATA bit 4 of frame 0x55 → all outputs 0 immediately. After release, the remainder of that frame produces no data_valid; the next frame 0xC3 (parity 0) yields data_out=8'hC3 with no errors.
- Frames 0x00 then 0xFF sent with zero idle gap → two data_valid pulses 176 cycles apart, data_out 8'h00 then 8'hFF, no errors.
